mult_table_ram: RTL and testbench

//  Parametrised times-table lookup: A_W x B_W operand table held in an internal RAM.

---
 rtl/mult_table_ram.sv | 131 +++++++++++++
 tb/tb_mult_table_ram.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mult_table_ram.sv
// ============================================================================
//  Module   : mult_table_ram
//  Purpose  : Times-table lookup RAM, filled after reset by repeated addition.
//             Optional saturating store when OUT_W is narrower than A_W+B_W:
//             define MULT_TABLE_SAT_EN (default build truncates).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_table_ram #(
    parameter int A_W   = 3,
    parameter int B_W   = 3,
    parameter int OUT_W = A_W + B_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [A_W-1:0]   i_a,
    input  logic [B_W-1:0]   i_b,
    input  logic             i_read,
    output logic             o_ready,
    output logic [OUT_W-1:0] o_result,
    output logic             o_valid,
    output logic             o_rd_err
);

    localparam int AB_W  = A_W + B_W;
    localparam int DEPTH = 1 << AB_W;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [A_W-1:0]    r_ai;
    logic [A_W-1:0]    w_ai_nxt;
    logic [B_W-1:0]    r_bi;
    logic [B_W-1:0]    w_bi_nxt;
    logic [AB_W-1:0]   r_acc;
    logic [AB_W-1:0]   w_acc_nxt;
    logic              w_we;
    logic [OUT_W-1:0]  w_store;
    logic [OUT_W-1:0]  r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_ai    <= '0;
            r_bi    <= '0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ai    <= w_ai_nxt;
            r_bi    <= w_bi_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    // acc always holds ai*bi for the entry being written this cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_ai_nxt    = r_ai;
        w_bi_nxt    = r_bi;
        w_acc_nxt   = r_acc;
        w_we        = 1'b0;
        case (r_state)
            S_INIT: begin
                w_we = 1'b1;
                if (&r_bi) begin
                    w_bi_nxt  = '0;
                    w_acc_nxt = '0;
                    w_ai_nxt  = r_ai + A_W'(1);
                    if (&r_ai) begin
                        w_state_nxt = S_READY;
                    end
                end else begin
                    w_bi_nxt  = r_bi + B_W'(1);
                    w_acc_nxt = r_acc + AB_W'(r_ai);
                end
            end
            S_READY: begin
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
    end

    generate
        if (OUT_W >= AB_W) begin : g_zext
            assign w_store = OUT_W'(r_acc);
        end else begin : g_narrow
`ifdef MULT_TABLE_SAT_EN
            assign w_store = (|r_acc[AB_W-1:OUT_W]) ? {OUT_W{1'b1}} : r_acc[OUT_W-1:0];
`else
            assign w_store = r_acc[OUT_W-1:0];
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_ai, r_bi}] <= w_store;
        end
    end

    assign o_ready = (r_state == S_READY);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_result <= '0;
            o_valid  <= 1'b0;
            o_rd_err <= 1'b0;
        end else begin
            o_valid  <= 1'b0;
            o_rd_err <= 1'b0;
            if (i_read) begin
                if (o_ready) begin
                    o_result <= r_mem[{i_a, i_b}];
                    o_valid  <= 1'b1;
                end else begin
                    o_rd_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_table_ram.sv
// ============================================================================
//  Module   : tb_mult_table_ram
//  Purpose  : Directed scoreboard bench for three mult_table_ram configurations
//             (3x3 full width, 3x3 into 4 bits, 4x2) running in lockstep.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_table_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_read = 1'b0;
    logic [2:0] i_a = '0;
    logic [2:0] i_b = '0;
    logic [3:0] i_a2 = '0;
    logic [1:0] i_b2 = '0;

    logic       o_ready0, o_valid0, o_rd_err0;
    logic [5:0] o_result0;
    logic       o_ready1, o_valid1, o_rd_err1;
    logic [3:0] o_result1;
    logic       o_ready2, o_valid2, o_rd_err2;
    logic [5:0] o_result2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult_table_ram #(.A_W(3), .B_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_read(i_read),
        .o_ready(o_ready0), .o_result(o_result0), .o_valid(o_valid0), .o_rd_err(o_rd_err0)
    );

    mult_table_ram #(.A_W(3), .B_W(3), .OUT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_a(i_a), .i_b(i_b), .i_read(i_read),
        .o_ready(o_ready1), .o_result(o_result1), .o_valid(o_valid1), .o_rd_err(o_rd_err1)
    );

    mult_table_ram #(.A_W(4), .B_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .i_a(i_a2), .i_b(i_b2), .i_read(i_read),
        .o_ready(o_ready2), .o_result(o_result2), .o_valid(o_valid2), .o_rd_err(o_rd_err2)
    );

    typedef struct {
        bit v;
        bit e;
        int r0;
        int r1;
        int r2;
    } exp_t;

    exp_t q[$];

    int m_cnt = 0;
    bit m_ready = 1'b0;
    int m_r0 = 0;
    int m_r1 = 0;
    int m_r2 = 0;

    function automatic int store4(input int p);
`ifdef MULT_TABLE_SAT_EN
        return (p > 15) ? 15 : p;
`else
        return p % 16;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all(input exp_t e);
        chk("ready0", 32'(o_ready0), 32'(m_ready));
        chk("ready1", 32'(o_ready1), 32'(m_ready));
        chk("ready2", 32'(o_ready2), 32'(m_ready));
        chk("valid0", 32'(o_valid0), 32'(e.v));
        chk("valid1", 32'(o_valid1), 32'(e.v));
        chk("valid2", 32'(o_valid2), 32'(e.v));
        chk("rderr0", 32'(o_rd_err0), 32'(e.e));
        chk("rderr1", 32'(o_rd_err1), 32'(e.e));
        chk("rderr2", 32'(o_rd_err2), 32'(e.e));
        chk("result0", 32'(o_result0), e.r0);
        chk("result1", 32'(o_result1), e.r1);
        chk("result2", 32'(o_result2), e.r2);
    endtask

    // One clock with optional read; idx drives both operand splits.
    task automatic step(input bit rd, input logic [5:0] idx);
        exp_t e;
        i_read = rd;
        i_a    = idx[5:3];
        i_b    = idx[2:0];
        i_a2   = idx[5:2];
        i_b2   = idx[1:0];
        e.v = 1'b0;
        e.e = 1'b0;
        if (rd && m_ready) begin
            e.v  = 1'b1;
            m_r0 = int'(idx[5:3]) * int'(idx[2:0]);
            m_r1 = store4(m_r0);
            m_r2 = int'(idx[5:2]) * int'(idx[1:0]);
        end else if (rd) begin
            e.e = 1'b1;
        end
        e.r0 = m_r0;
        e.r1 = m_r1;
        e.r2 = m_r2;
        q.push_back(e);
        @(posedge clk);
        #1;
        m_cnt++;
        m_ready = (m_cnt >= 64);
        i_read  = 1'b0;
        chk_all(q.pop_front());
    endtask

    // Hold reset for n edges (optionally with a read pending), then release.
    task automatic do_reset(input int n, input bit rd);
        exp_t e;
        rst    = 1'b1;
        i_read = rd;
        i_a    = 3'd7;
        i_b    = 3'd7;
        i_a2   = 4'd15;
        i_b2   = 2'd3;
        m_cnt   = 0;
        m_ready = 1'b0;
        m_r0 = 0;
        m_r1 = 0;
        m_r2 = 0;
        e = '{v: 1'b0, e: 1'b0, r0: 0, r1: 0, r2: 0};
        for (int i = 0; i < n; i++) begin
            q.push_back(e);
            @(posedge clk);
            #1;
            i_read = 1'b0;
            chk_all(q.pop_front());
        end
        rst = 1'b0;
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 6'd0);
        end
    endtask

    initial begin
        do_reset(2, 1'b0);

        run_idle(10);
        step(1'b1, {3'd2, 3'd3});
        run_idle(52);
        step(1'b1, {3'd1, 3'd1});
        chk("ready_at_64", 32'(o_ready0), 32'd1);

        step(1'b1, {3'd7, 3'd7});
        step(1'b1, {3'd3, 3'd5});
        step(1'b1, {3'd0, 3'd6});
        step(1'b0, 6'd0);
        step(1'b1, {3'd5, 3'd3});
        step(1'b1, 6'd63);
        step(1'b0, 6'd0);

        for (int i = 0; i < 64; i++) begin
            step(1'b1, 6'(i));
        end
        step(1'b0, 6'd0);

        do_reset(1, 1'b0);
        run_idle(30);
        do_reset(2, 1'b0);
        run_idle(63);
        step(1'b1, {3'd6, 3'd7});
        step(1'b1, {3'd4, 3'd4});
        step(1'b1, 6'd63);

        do_reset(1, 1'b1);
        run_idle(64);
        step(1'b1, {3'd7, 3'd6});
        for (int i = 63; i >= 0; i--) begin
            step(1'b1, 6'(i));
        end
        step(1'b0, 6'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
